// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and the
// default number of byte lanes per written word.
package loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int N_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian word one byte at a time; exposes the word and lane
// strobes including the byte being pushed this cycle.
module byte_packer
  import loader_pkg::*;
#(
  parameter int LAU = 8,
  parameter int NB  = N_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [LAU-1:0]    byte_i,
  output logic              last_lane_o,
  output logic [NB*LAU-1:0] word_next_o,
  output logic [NB-1:0]     strb_next_o
);

  localparam int LW = (NB > 1) ? $clog2(NB) : 1;

  logic [LW-1:0]     lane;
  logic [NB*LAU-1:0] word;
  logic [NB-1:0]     strb;

  assign last_lane_o = (lane == LW'(NB - 1));

  always_comb begin
    word_next_o = word;
    strb_next_o = strb;
    if (push_i) begin
      word_next_o[lane*LAU +: LAU] = byte_i;
      strb_next_o[lane]            = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      lane <= '0;
      word <= '0;
      strb <= '0;
    end else if (push_i) begin
      lane <= lane + LW'(1);
      word <= word_next_o;
      strb <= strb_next_o;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams an image byte-by-byte into word writes of instruction memory and
// holds the core in reset until the whole image has been written.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// RECV  | accepting image bytes into the packer
// WRITE | one-cycle memory write of the assembled word
// DONE  | image written, core released
module imem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LAU        = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDR_WIDTH-1:0]     base_addr_i,
  input  logic [ADDR_WIDTH-1:0]     len_i,
  input  logic                      byte_valid_i,
  input  logic [LAU-1:0]            byte_data_i,
  output logic                      byte_ready_o,
  output logic                      we_o,
  output logic [ADDR_WIDTH-1:0]     waddr_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic [DATA_WIDTH/LAU-1:0] wstrb_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      core_rst_o
);

  localparam int NB = DATA_WIDTH / LAU;
  localparam int SH = $clog2(NB);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] byte_cnt;
  logic [ADDR_WIDTH-1:0] word_cnt;

  logic              xfer;
  logic              pk_clear;
  logic              last_lane;
  logic [NB*LAU-1:0] word_next;
  logic [NB-1:0]     strb_next;

  // byte_ready_o is only ever high while in RECV, so it alone qualifies a transfer
  assign xfer     = byte_valid_i && byte_ready_o;
  assign pk_clear = (state == S_WRITE) ||
                    (((state == S_IDLE) || (state == S_DONE)) && start_i);

  byte_packer #(
    .LAU (LAU),
    .NB  (NB)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (pk_clear),
    .push_i      (xfer),
    .byte_i      (byte_data_i),
    .last_lane_o (last_lane),
    .word_next_o (word_next),
    .strb_next_o (strb_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      base         <= '0;
      len          <= '0;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      byte_ready_o <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
      wstrb_o      <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      core_rst_o   <= 1'b1;
    end else begin
      we_o    <= 1'b0;
      wstrb_o <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            base     <= base_addr_i & ~ADDR_WIDTH'(NB - 1);
            len      <= len_i;
            byte_cnt <= '0;
            word_cnt <= '0;
            if (len_i == '0) begin
              state        <= S_DONE;
              byte_ready_o <= 1'b0;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
              core_rst_o   <= 1'b0;
            end else begin
              state        <= S_RECV;
              byte_ready_o <= 1'b1;
              busy_o       <= 1'b1;
              done_o       <= 1'b0;
              core_rst_o   <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + ADDR_WIDTH'(1);
            if (last_lane || (byte_cnt + ADDR_WIDTH'(1) == len)) begin
              state        <= S_WRITE;
              byte_ready_o <= 1'b0;
              we_o         <= 1'b1;
              waddr_o      <= base + (word_cnt << SH);
              wdata_o      <= word_next;
              wstrb_o      <= strb_next;
            end
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + ADDR_WIDTH'(1);
          if (byte_cnt == len) begin
            state        <= S_DONE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            core_rst_o   <= 1'b0;
          end else begin
            state        <= S_RECV;
            byte_ready_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected writes are computed
// from the image bytes and checked by an independent write monitor.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] len_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic        we_o;
  logic [31:0] waddr_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        busy_o;
  logic        done_o;
  logic        core_rst_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t       q[$];
  logic [7:0] img[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk_i = ~clk_i;

  imem_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .wstrb_o      (wstrb_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .core_rst_o   (core_rst_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: image split into 4-byte words, little-endian, aligned base, wrapping address.
  task automatic push_expect(input logic [31:0] base, input int len);
    exp_t e;
    logic [31:0] a;
    a = base & ~32'h3;
    for (int w = 0; w * 4 < len; w++) begin
      e.addr = a + 32'(w * 4);
      e.data = '0;
      e.strb = '0;
      for (int b = 0; b < 4; b++) begin
        if (w * 4 + b < len) begin
          e.data = e.data | (32'(img[w*4+b]) << (8 * b));
          e.strb[b] = 1'b1;
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic fill_random(input int len);
    img.delete();
    for (int i = 0; i < len; i++) img.push_back(8'($urandom));
  endtask

  task automatic do_start(input logic [31:0] base, input int len);
    @(negedge clk_i);
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = 32'(len);
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  // mode 0: always valid, 1: toggle valid each cycle, 2: random stalls
  task automatic feed(input int n, input int mode, input bit poke);
    int i = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit v;
    while (i < n && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 2) != 0);
      tog = !tog;
      byte_valid_i = v;
      byte_data_i  = v ? img[i] : 8'($urandom);
      if (poke) begin
        start_i     = 1'b1;
        base_addr_i = $urandom;
        len_i       = 32'($urandom_range(0, 9));
      end
      if (v && byte_ready_o) i++;
    end
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", i, n);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    start_i      = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!done_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk({nm, "_done"}, done_o, 1);
    chk({nm, "_core_rst"}, core_rst_o, 0);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_writes_left"}, q.size(), 0);
  endtask

  task automatic session(input string nm, input logic [31:0] base, input int len,
                         input int mode, input bit poke);
    push_expect(base, len);
    do_start(base, len);
    feed(len, mode, poke);
    wait_done(nm);
  endtask

  // Write monitor: every strobe must match the oldest outstanding expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i !== 1'b1) begin
        if (we_o === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%0h strb=%0h required=none",
                     waddr_o, wdata_o, wstrb_o);
          end else begin
            e = q.pop_front();
            if ({waddr_o, wdata_o, wstrb_o} !== {e.addr, e.data, e.strb}) begin
              errors++;
              $display("FAIL write actual=(%0h,%0h,%0h) required=(%0h,%0h,%0h)",
                       waddr_o, wdata_o, wstrb_o, e.addr, e.data, e.strb);
            end
          end
          chk("ready_in_write", byte_ready_o, 0);
          chk("busy_in_write", busy_o, 1);
        end else begin
          chk("strb_idle", wstrb_o, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    base_addr_i  = '0;
    len_i        = '0;
    byte_valid_i = 1'b0;
    byte_data_i  = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", byte_ready_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_strb", wstrb_o, 0);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_core_rst", core_rst_o, 1);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_core_rst", core_rst_o, 1);
    chk("idle_done", done_o, 0);

    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    session("two_words", 32'h0, 8, 0, 0);

    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    session("partial", 32'h100, 6, 0, 0);

    do_start(32'h40, 0);
    chk("len0_done_next", done_o, 1);
    wait_done("len0");

    fill_random(4);
    push_expect(32'h20, 4);
    do_start(32'h20, 4);
    feed(4, 1, 0);
    chk("toggle_we_after_4th", we_o, 1);
    chk("toggle_ready_low", byte_ready_o, 0);
    wait_done("toggle");

    fill_random(4);
    do_start(32'h0, 4);
    feed(2, 0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("abort_core_rst", core_rst_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_ready", byte_ready_o, 0);
    fill_random(4);
    session("after_abort", 32'h8, 4, 0, 0);

    fill_random(8);
    session("wrap", 32'hFFFF_FFFC, 8, 2, 0);
    fill_random(4);
    session("unaligned", 32'h3, 4, 0, 0);

    for (int s = 0; s < 25; s++) begin
      int len;
      len = $urandom_range(0, 13);
      fill_random(len);
      session("random", $urandom, len, 2 * int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, written word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter LAU, default 8, least addressable unit in bits; N_BYTES = DATA_WIDTH/LAU (4), derived, not overridable.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 start_i  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-007 base_addr_i  input  ADDR_WIDTH  first byte address of the image; sampled on accepted start_i.
REQ-008 len_i  input  ADDR_WIDTH  image length in bytes; sampled on accepted start_i.
REQ-009 byte_valid_i  input  1  byte_data_i valid.
REQ-010 byte_data_i  input  LAU  next image byte, file order.
REQ-011 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-012 we_o  output  1  one-cycle memory write strobe.
REQ-013 waddr_o  output  ADDR_WIDTH  word-aligned write byte address.
REQ-014 wdata_o  output  DATA_WIDTH  little-endian assembled word.
REQ-015 wstrb_o  output  N_BYTES  byte-lane enables for the write.
REQ-016 busy_o  output  1  session in progress (RECV or WRITE).
REQ-017 done_o  output  1  image fully written; level.
REQ-018 core_rst_o  output  1  holds the core in reset until the image is loaded.

Function
REQ-019 FSM states IDLE, RECV, WRITE, DONE; exactly one state active.
REQ-020 IDLE/DONE + start_i: latch base_addr_i with bits [1:0] forced to 0, latch len_i, clear byte count, lane index, and assembly register; go to RECV, or directly to DONE if len_i == 0 (no write issued).
REQ-021 start_i in RECV or WRITE is ignored.
REQ-022 byte_ready_o = 1 only in RECV; a byte transfers when byte_valid_i && byte_ready_o.
REQ-023 Transferred byte goes to lane k = current lane index, bits [8k+7:8k] of the assembly word; its wstrb bit is set; lane index and byte count increment.
REQ-024 RECV -> WRITE on the transfer that fills lane 3 or makes byte count equal len.
REQ-025 WRITE lasts exactly one cycle: we_o = 1, waddr_o = base + 4*word_count (mod 2^ADDR_WIDTH), wdata_o = assembly word, wstrb_o = collected lanes; unfilled lanes read as 0.
REQ-026 After WRITE: word_count increments, lane index, strobes, and assembly register clear; go to RECV if bytes remain, else DONE.
REQ-027 Throughput: 4 byte cycles + 1 write cycle per full word; a byte-stream stall (byte_valid_i = 0) holds all state.
REQ-028 we_o, wstrb_o = 0 outside WRITE; waddr_o/wdata_o don't-care when we_o = 0.
REQ-029 busy_o = 1 in RECV and WRITE; done_o = 1 only in DONE.
REQ-030 core_rst_o = 1 in IDLE, RECV, WRITE; 0 in DONE.
REQ-031 Address wraps modulo 2^ADDR_WIDTH; no error signalled.

Reset
REQ-032 rst_i = 1 at a clock edge forces IDLE, clears all counters and registers, overriding any event in that cycle, mid-session included; no partial word is written.
REQ-033 Output values during and after reset: byte_ready_o = 0, we_o = 0, wstrb_o = 0, waddr_o = 0, wdata_o = 0, busy_o = 0, done_o = 0, core_rst_o = 1.

Structure
REQ-034 Shared package loader_pkg holds the FSM state enum (IDLE, RECV, WRITE, DONE) and the N_BYTES constant.
REQ-035 Optional single sub-module byte_packer (lane index, strobe, and assembly register); FSM and counters remain in imem_loader.

Verification
REQ-036 base = 0x0, len = 8, bytes 13 00 00 00 93 00 10 00 -> two writes: (0x0, 0x00000013, 4'hF) and (0x4, 0x00100093, 4'hF); then done_o = 1, core_rst_o = 0.
REQ-037 base = 0x100, len = 6, bytes 11 22 33 44 55 66 -> (0x100, 0x44332211, 4'hF), (0x104, 0x00006655, 4'b0011); then DONE.
REQ-038 len = 0 with start_i -> DONE next cycle, we_o never asserted.
REQ-039 byte_valid_i toggled 1/0 every cycle, len = 4 -> one write, issued 1 cycle after the 4th accepted byte; byte_ready_o low only in the WRITE cycle.
REQ-040 rst_i asserted after 2 of 4 bytes -> IDLE, no write, core_rst_o = 1; new start with base = 0x8 writes at 0x8.
REQ-041 base = 0xFFFFFFFC, len = 8 -> writes at 0xFFFFFFFC then 0x00000000; base = 0x3 -> first write at 0x0.
